// File: rtl/banco_registradores_pkg.sv
// banco_pkg: shared types and defaults for the register file.
// Build option: BANCO_BYPASS_EN enables write-to-read forwarding.
package banco_pkg;

    typedef enum logic {
        LIMPANDO = 1'b0,
        PRONTO   = 1'b1
    } estado_banco_t;

    localparam int REG_ZERO       = 0;
    localparam int LARGURA_PADRAO = 32;
    localparam int N_REG_PADRAO   = 32;

endpackage

// File: rtl/banco_registradores_if.sv
// Read/write bus of the register file.
// master = write-back/decode side, slave = register file.
interface banco_registradores_if #(
    parameter int LARGURA = 32,
    parameter int N_REG   = 32
);
    localparam int ADDR_W = $clog2(N_REG);

    logic [ADDR_W-1:0]  reg_leitura1;
    logic [ADDR_W-1:0]  reg_leitura2;
    logic [ADDR_W-1:0]  reg_escrita;
    logic [LARGURA-1:0] dados_escrita;
    logic               escreve_reg;
    logic [LARGURA-1:0] dados1;
    logic [LARGURA-1:0] dados2;
    logic               pronto;

    modport master (
        output reg_leitura1, reg_leitura2,
        output reg_escrita, dados_escrita, escreve_reg,
        input  dados1, dados2, pronto
    );

    modport slave (
        input  reg_leitura1, reg_leitura2,
        input  reg_escrita, dados_escrita, escreve_reg,
        output dados1, dados2, pronto
    );
endinterface

// File: rtl/banco_registradores_limpeza_seq.sv
// limpeza_seq: post-reset clear sequencer, one entry per cycle.
// Build option: none (BANCO_BYPASS_EN lives in the top).
module limpeza_seq
    import banco_pkg::*;
#(
    parameter int N_REG  = N_REG_PADRAO,
    parameter int ADDR_W = $clog2(N_REG)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              limpa_en,
    output logic [ADDR_W-1:0] limpa_addr,
    output logic              pronto
);
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_REG - 1);

    estado_banco_t     estado;
    logic [ADDR_W-1:0] contador;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= LIMPANDO;
            contador <= '0;
            pronto   <= 1'b0;
        end else begin
            unique case (estado)
                LIMPANDO: begin
                    // wraps to 0 on the last entry, then sits unused
                    contador <= contador + ADDR_W'(1);
                    if (contador == ULTIMO) begin
                        estado <= PRONTO;
                        pronto <= 1'b1;
                    end
                end
                PRONTO: ;
                default: estado <= LIMPANDO;
            endcase
        end
    end

    assign limpa_en   = (estado == LIMPANDO) && !rst;
    assign limpa_addr = contador;

endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: 32x32 register file, 2 comb reads, 1 sync write.
// Build option: define BANCO_BYPASS_EN for write-to-read forwarding.
module banco_registradores
    import banco_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int N_REG   = N_REG_PADRAO
) (
    input logic                  clk,
    input logic                  rst,
    banco_registradores_if.slave bus
);
    localparam int ADDR_W = $clog2(N_REG);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [LARGURA-1:0] mem [N_REG];
    logic               limpa_en;
    logic [ADDR_W-1:0]  limpa_addr;
    logic               pronto;
    logic               escrita_ok;

    limpeza_seq #(
        .N_REG  (N_REG),
        .ADDR_W (ADDR_W)
    ) u_limpeza (
        .clk        (clk),
        .rst        (rst),
        .limpa_en   (limpa_en),
        .limpa_addr (limpa_addr),
        .pronto     (pronto)
    );

    assign escrita_ok = pronto && !rst && bus.escreve_reg
                      && (bus.reg_escrita != ZERO);

    // single write port: clear has priority, no reset on the array
    always_ff @(posedge clk) begin
        if (limpa_en)
            mem[limpa_addr] <= '0;
        else if (escrita_ok)
            mem[bus.reg_escrita] <= bus.dados_escrita;
    end

    always_comb begin
        bus.dados1 = '0;
        bus.dados2 = '0;
        if (pronto && bus.reg_leitura1 != ZERO)
            bus.dados1 = mem[bus.reg_leitura1];
        if (pronto && bus.reg_leitura2 != ZERO)
            bus.dados2 = mem[bus.reg_leitura2];
`ifdef BANCO_BYPASS_EN
        if (escrita_ok && bus.reg_leitura1 == bus.reg_escrita)
            bus.dados1 = bus.dados_escrita;
        if (escrita_ok && bus.reg_leitura2 == bus.reg_escrita)
            bus.dados2 = bus.dados_escrita;
`endif
    end

    assign bus.pronto = pronto;

endmodule
